// File: rtl/conv_pkg.sv
// Shared K=3 (7,5) convolutional code definitions for the encoder and Viterbi decoder.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package conv_pkg;

   localparam int         K         = 3;
   localparam int         M         = K - 1;
   localparam int         MAX_FRAME = 32;
   localparam logic [2:0] G0        = 3'b111;
   localparam logic [2:0] G1        = 3'b101;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      ENCODE = 2'd2,
      TAIL   = 2'd3
   } enc_state_t;

   // Register layout is {st[1], st[0], b}; the newest bit sits in the LSB.
   function automatic logic [1:0] conv_sym(input logic [1:0] st, input logic b);
      logic [2:0] r;
      r = {st, b};
      return {^(r & G0), ^(r & G1)};
   endfunction

   function automatic logic [1:0] conv_next(input logic [1:0] st, input logic b);
      return {st[0], b};
   endfunction

endpackage

// File: rtl/conv_enc_trellis.sv
// One trellis step: (state, input bit) -> (symbol {g0,g1}, next state).
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module conv_enc_trellis (
   input  logic [1:0] st,
   input  logic       b,
   output logic [1:0] sym,
   output logic [1:0] next_st
);
   import conv_pkg::*;

   always_comb begin
      sym     = conv_sym(st, b);
      next_st = conv_next(st, b);
   end

endmodule

// File: rtl/conv_encoder_k3.sv
// Frame-buffered rate-1/2 K=3 encoder; CONV_ENC_TAIL_EN appends a 2-symbol zero tail.
// Latency: first symbol valid the cycle after start; one symbol per cycle with sym_ready high.
// Backpressure: sym_out/sym_valid hold while sym_ready is low; in_ready drops when the buffer is full.
module conv_encoder_k3 #(
   parameter int MAX_FRAME = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic       in_bit,
   output logic       in_ready,
   input  logic       start,
   output logic       sym_valid,
   output logic [1:0] sym_out,
   input  logic       sym_ready,
   output logic       sym_last,
   output logic       busy,
   output logic       frame_done
);
   import conv_pkg::*;

`ifdef CONV_ENC_TAIL_EN
   localparam bit TAIL_EN = 1'b1;
`else
   localparam bit TAIL_EN = 1'b0;
`endif

   localparam int         AW  = $clog2(MAX_FRAME);
   localparam logic [5:0] CAP = 6'(TAIL_EN ? MAX_FRAME - 2 : MAX_FRAME);

   enc_state_t state, state_nxt;
   logic [5:0] count, len, idx;
   logic [1:0] enc_st;
   logic       tail_cnt;
   logic       frame_buf [MAX_FRAME];

   logic       loading, accept, go, hs, enc_last, cur_b, done_nxt;
   logic [1:0] t_sym, t_next;

   conv_enc_trellis u_trellis (
      .st      (enc_st),
      .b       (cur_b),
      .sym     (t_sym),
      .next_st (t_next)
   );

   always_comb begin
      loading   = (state == IDLE) || (state == LOAD);
      busy      = (state == ENCODE) || (state == TAIL);
      in_ready  = loading && (count < CAP);
      accept    = in_valid && in_ready;
      // A bit accepted alongside start still counts toward a non-empty frame.
      go        = loading && start && ((count != 6'd0) || accept);
      sym_valid = busy;
      hs        = sym_valid && sym_ready;
      cur_b     = (state == ENCODE) ? frame_buf[idx[AW-1:0]] : 1'b0;
      sym_out   = sym_valid ? t_sym : 2'b00;
      enc_last  = (state == ENCODE) && (idx == len - 6'd1);
      sym_last  = (enc_last && !TAIL_EN) || ((state == TAIL) && tail_cnt);
      done_nxt  = hs && sym_last;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, LOAD: begin
            if (go)          state_nxt = ENCODE;
            else if (accept) state_nxt = LOAD;
         end
         ENCODE: begin
            if (hs && enc_last) state_nxt = TAIL_EN ? TAIL : IDLE;
         end
         TAIL: begin
            if (hs && tail_cnt) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         count      <= 6'd0;
         len        <= 6'd0;
         idx        <= 6'd0;
         enc_st     <= 2'b00;
         tail_cnt   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         frame_done <= done_nxt;
         if (accept) count <= count + 6'd1;
         if (go) begin
            len      <= count + {5'd0, accept};
            enc_st   <= 2'b00;
            idx      <= 6'd0;
            tail_cnt <= 1'b0;
         end
         if (hs) begin
            enc_st <= t_next;
            if (state == ENCODE) idx <= idx + 6'd1;
            if (state == TAIL)   tail_cnt <= tail_cnt + 1'b1;
         end
         if (done_nxt) count <= 6'd0;
      end
   end

   // Buffer holds no reset; stale contents are never read past len.
   always_ff @(posedge clk) begin
      if (accept) frame_buf[count[AW-1:0]] <= in_bit;
   end

endmodule

// File: tb/tb_conv_encoder_k3.sv
// Directed bench for conv_encoder_k3; expectations follow CONV_ENC_TAIL_EN when defined.
module tb_conv_encoder_k3;

   logic       clk = 1'b0;
   logic       rst, in_valid, in_bit, in_ready, start;
   logic       sym_valid, sym_ready, sym_last, busy, frame_done;
   logic [1:0] sym_out;

   int checks   = 0;
   int failures = 0;

`ifdef CONV_ENC_TAIL_EN
   localparam bit TAIL_EN = 1'b1;
   localparam int CAP     = 30;
`else
   localparam bit TAIL_EN = 1'b0;
   localparam int CAP     = 32;
`endif

   logic [1:0] exp_q[$];

   conv_encoder_k3 dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_bit     (in_bit),
      .in_ready   (in_ready),
      .start      (start),
      .sym_valid  (sym_valid),
      .sym_out    (sym_out),
      .sym_ready  (sym_ready),
      .sym_last   (sym_last),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Bits are presented LSB first; called and returns at a negedge.
   task automatic load(input logic [63:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_bit   = bits[i];
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_bit   = 1'b0;
   endtask

   task automatic run_frame(input int stall_at);
      int n;
      n         = exp_q.size();
      start     = 1'b1;
      sym_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i == stall_at) begin
            sym_ready = 1'b0;
            repeat (3) begin
               chk("hold_vld", sym_valid, 1'b1);
               chk("hold_sym", sym_out, exp_q[i]);
               @(negedge clk);
            end
            sym_ready = 1'b1;
         end
         chk("sym_vld", sym_valid, 1'b1);
         chk("sym_out", sym_out, exp_q[i]);
         chk("sym_last", sym_last, (i == n - 1));
         chk("busy", busy, 1'b1);
         chk("no_done", frame_done, 1'b0);
         @(negedge clk);
      end
      chk("frame_done", frame_done, 1'b1);
      chk("end_vld", sym_valid, 1'b0);
      chk("end_sym", sym_out, 2'b00);
      chk("end_rdy", in_ready, 1'b1);
      chk("end_busy", busy, 1'b0);
      @(negedge clk);
      chk("done_pulse", frame_done, 1'b0);
   endtask

   function automatic logic ovf_bit(input int i);
      return ((i % 3) == 1) ^ ((i % 7) == 0);
   endfunction

   initial begin
      int acc;
      logic [1:0] st;
      logic b;

      rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; start = 1'b0; sym_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_sym_vld", sym_valid, 1'b0);
      chk("rst_sym_out", sym_out, 2'b00);
      chk("rst_sym_last", sym_last, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", frame_done, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // start on an empty buffer is ignored
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("empty_start_busy", busy, 1'b0);
      chk("empty_start_vld", sym_valid, 1'b0);
      chk("empty_start_rdy", in_ready, 1'b1);
      @(negedge clk);

      // bits 1,0,1,1
      load(64'b1101, 4);
      exp_q = '{2'b11, 2'b10, 2'b00, 2'b01};
      if (TAIL_EN) begin exp_q.push_back(2'b01); exp_q.push_back(2'b11); end
      run_frame(-1);
      chk("final_enc_st", dut.enc_st, TAIL_EN ? 2'b00 : 2'b11);

      // same frame with a 3-cycle stall on the second symbol
      load(64'b1101, 4);
      run_frame(1);

      // 8 zeros
      load(64'b0, 8);
      exp_q = {};
      repeat (8 + (TAIL_EN ? 2 : 0)) exp_q.push_back(2'b00);
      run_frame(-1);

      // bits 1,0 then bit 1 together with start: encoded last
      load(64'b01, 2);
      in_valid = 1'b1;
      in_bit   = 1'b1;
      exp_q = '{2'b11, 2'b10, 2'b00};
      if (TAIL_EN) begin exp_q.push_back(2'b10); exp_q.push_back(2'b11); end
      start     = 1'b1;
      sym_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_bit   = 1'b0;
      start    = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         chk("same_cyc_vld", sym_valid, 1'b1);
         chk("same_cyc_sym", sym_out, exp_q[i]);
         chk("same_cyc_last", sym_last, (i == exp_q.size() - 1));
         @(negedge clk);
      end
      chk("same_cyc_done", frame_done, 1'b1);
      @(negedge clk);

      // overflow: offer 35 bits
      acc = 0;
      exp_q = {};
      st = 2'b00;
      for (int i = 0; i < 35; i++) begin
         in_valid = 1'b1;
         in_bit   = ovf_bit(i);
         if (in_ready) begin
            b = ovf_bit(i);
            exp_q.push_back({st[1] ^ st[0] ^ b, st[1] ^ b});
            st = {st[0], b};
            acc++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("ovf_accepted", acc, CAP);
      chk("ovf_in_ready", in_ready, 1'b0);
      if (TAIL_EN) begin
         exp_q.push_back({st[1] ^ st[0], st[1]});
         st = {st[0], 1'b0};
         exp_q.push_back({st[1] ^ st[0], st[1]});
      end
      chk("ovf_nsym", exp_q.size(), 32);
      run_frame(-1);

      // reset during ENCODE
      load(64'b1101, 4);
      start     = 1'b1;
      sym_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("pre_rst_busy", busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_enc_vld", sym_valid, 1'b0);
      chk("rst_enc_sym", sym_out, 2'b00);
      chk("rst_enc_rdy", in_ready, 1'b1);
      chk("rst_enc_state", dut.state, 2'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_done", frame_done, 1'b0);

      // recovery frame
      load(64'b1101, 4);
      exp_q = '{2'b11, 2'b10, 2'b00, 2'b01};
      if (TAIL_EN) begin exp_q.push_back(2'b01); exp_q.push_back(2'b11); end
      run_frame(-1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
